// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution / pooling datapath.
package conv_pkg;

    localparam int WIDTH_BIT = 16;
    localparam int POOL      = 2;

    typedef logic signed [WIDTH_BIT-1:0] pixel_t;

    function automatic pixel_t smax(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line of partial maxima: one write port, one async read port.
module pool_line_buffer #(
    parameter  int DEPTH     = 159,
    parameter  int WIDTH_BIT = 16,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH_BIT-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [WIDTH_BIT-1:0] rdata
);

    logic [WIDTH_BIT-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2_stream.sv
// Streaming 2x2 stride-2 max-pool; raster in, raster out, one line buffer.
module maxpool2_stream
    import conv_pkg::*;
#(
    parameter int SIZE      = 318,
    parameter int WIDTH_BIT = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH_BIT-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH_BIT-1:0] out_data,
    output logic                        out_last,
    output logic                        done
);

    localparam int OSIZE = SIZE / POOL;
    localparam int CW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int AW    = (OSIZE > 1) ? $clog2(OSIZE) : 1;

    typedef logic signed [WIDTH_BIT-1:0] pix_t;

    function automatic pix_t pmax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0] row;
    logic [CW-1:0] col;
    pix_t          hold;
    pix_t          lb_rdata;
    pix_t          pair_max;
    pix_t          quad_max;
    logic [AW-1:0] lb_addr;
    logic          in_beat;
    logic          out_beat;
    logic          in_pool;
    logic          lb_we;
    logic          load;
    logic          row_end;
    logic          col_end;
    logic          at_last;

    assign in_ready = !out_valid || out_ready;
    assign in_beat  = in_valid && in_ready;
    assign out_beat = out_valid && out_ready;

    assign col_end = (col == CW'(SIZE - 1));
    assign row_end = (row == CW'(SIZE - 1));
    // Trailing row/col of an odd-sized map fall outside every window
    assign in_pool = (int'(row) < 2 * OSIZE) && (int'(col) < 2 * OSIZE);
    assign at_last = (row == CW'(2 * OSIZE - 1)) && (col == CW'(2 * OSIZE - 1));

    assign lb_addr  = AW'(col >> 1);
    assign pair_max = pmax(hold, in_data);
    assign quad_max = pmax(lb_rdata, pair_max);
    assign lb_we    = in_beat && in_pool && col[0] && !row[0];
    assign load     = in_beat && in_pool && col[0] && row[0];

    pool_line_buffer #(
        .DEPTH     (OSIZE),
        .WIDTH_BIT (WIDTH_BIT)
    ) u_line (
        .clock (clock),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair_max),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row  <= '0;
            col  <= '0;
            hold <= '0;
        end else if (in_beat) begin
            if (!col[0]) hold <= in_data;
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Loads only happen when in_ready, so a pending result is never overwritten
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= out_beat && out_last;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= quad_max;
                out_last  <= at_last;
            end else if (out_beat) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maxpool2_stream.sv
// Directed bench for maxpool2_stream with SIZE=4 and SIZE=5 instances.
module tb_maxpool2_stream;

    logic clock;
    logic reset;

    logic               in_valid4, in_ready4, out_valid4, out_ready4;
    logic               out_last4, done4;
    logic signed [15:0] in_data4, out_data4;

    logic               in_valid5, in_ready5, out_valid5, out_ready5;
    logic               out_last5, done5;
    logic signed [15:0] in_data5, out_data5;

    int tests;
    int fails;

    int q4[$];
    int l4[$];
    int q5[$];
    int l5[$];
    int done_cnt4, done_bad4, done_cnt5, done_bad5;
    int stall5;
    logic lastbeat4, lastbeat5;

    maxpool2_stream #(.SIZE(4), .WIDTH_BIT(16)) u4 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .out_last  (out_last4),
        .done      (done4)
    );

    maxpool2_stream #(.SIZE(5), .WIDTH_BIT(16)) u5 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .in_data   (in_data5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_data  (out_data5),
        .out_last  (out_last5),
        .done      (done5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done4) begin
            done_cnt4++;
            if (!lastbeat4) done_bad4++;
        end
        if (done5) begin
            done_cnt5++;
            if (!lastbeat5) done_bad5++;
        end
        lastbeat4 = out_valid4 && out_ready4 && out_last4;
        lastbeat5 = out_valid5 && out_ready5 && out_last5;
        if (out_valid4 && out_ready4) begin
            q4.push_back(int'(out_data4));
            l4.push_back(int'(out_last4));
        end
        if (out_valid5 && out_ready5) begin
            q5.push_back(int'(out_data5));
            l5.push_back(int'(out_last5));
        end
        if (in_valid5 && !in_ready5) stall5++;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send4(input int v);
        int n;
        in_valid4 = 1'b1;
        in_data4  = 16'(v);
        n = 0;
        @(negedge clock);
        while (!in_ready4 && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (n >= 200) check("ready4_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid4 = 1'b0;
    endtask

    task automatic send5(input int v);
        int n;
        in_valid5 = 1'b1;
        in_data5  = 16'(v);
        n = 0;
        @(negedge clock);
        while (!in_ready5 && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (n >= 200) check("ready5_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid5 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        q4.delete();
        l4.delete();
        q5.delete();
        l5.delete();
        done_cnt4 = 0;
        done_bad4 = 0;
        done_cnt5 = 0;
        done_bad5 = 0;
        stall5    = 0;
    endtask

    task automatic check_frame(input string tag, input int sel,
                               input int e[8], input int n, input int nd);
        int got_n, dc, db;
        got_n = (sel == 4) ? q4.size() : q5.size();
        dc    = (sel == 4) ? done_cnt4 : done_cnt5;
        db    = (sel == 4) ? done_bad4 : done_bad5;
        check({tag, "_count"}, got_n, n);
        for (int i = 0; i < n && i < got_n; i++) begin
            if (sel == 4) begin
                check($sformatf("%s_data%0d", tag, i), q4[i], e[i]);
                check($sformatf("%s_last%0d", tag, i), l4[i],
                      int'((i % 4) == 3));
            end else begin
                check($sformatf("%s_data%0d", tag, i), q5[i], e[i]);
                check($sformatf("%s_last%0d", tag, i), l5[i],
                      int'((i % 4) == 3));
            end
        end
        check({tag, "_done_cnt"}, dc, nd);
        check({tag, "_done_late"}, db, 0);
        clear_obs();
    endtask

    task automatic stall_watch();
        int n;
        n = 0;
        while (!out_valid4 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 200) check("stall_timeout", 0, 1);
        out_ready4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("stall_rdy%0d", i), int'(in_ready4), 0);
            check($sformatf("stall_val%0d", i), int'(out_valid4), 1);
            check($sformatf("stall_dat%0d", i), int'(out_data4), 5);
        end
        @(posedge clock);
        #1;
        out_ready4 = 1'b1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        lastbeat4  = 1'b0;
        lastbeat5  = 1'b0;
        in_valid4  = 1'b0;
        in_data4   = '0;
        out_ready4 = 1'b1;
        in_valid5  = 1'b0;
        in_data5   = '0;
        out_ready5 = 1'b1;
        clear_obs();
        reset = 1'b1;
        @(negedge clock);
        check("rst_out_valid", int'(out_valid4), 0);
        check("rst_out_data", int'(out_data4), 0);
        check("rst_out_last", int'(out_last4), 0);
        check("rst_done", int'(done4), 0);
        check("rst_in_ready", int'(in_ready4), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);
        clear_obs();

        for (int i = 0; i < 16; i++) send4(i);
        idle(3);
        check_frame("ramp4", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, 4, 1);

        for (int i = 0; i < 16; i++) send4(i - 16);
        idle(3);
        check_frame("neg4", 4, '{-11, -9, -3, -1, 0, 0, 0, 0}, 4, 1);

        for (int i = 0; i < 25; i++) send5(i);
        idle(3);
        check("odd5_no_stall", stall5, 0);
        check_frame("odd5", 5, '{6, 8, 16, 18, 0, 0, 0, 0}, 4, 1);

        fork
            for (int i = 0; i < 16; i++) send4(i);
            stall_watch();
        join
        idle(3);
        check_frame("stall4", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, 4, 1);

        for (int i = 0; i < 16; i++) send4(i);
        for (int i = 0; i < 16; i++) send4(i + 100);
        idle(3);
        check_frame("b2b4", 4, '{5, 7, 13, 15, 105, 107, 113, 115}, 8, 2);

        for (int i = 0; i < 6; i++) send4(i + 40);
        idle(2);
        clear_obs();
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_valid", int'(out_valid4), 0);
        check("mid_rst_ready", int'(in_ready4), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 16; i++) send4(i);
        idle(3);
        check_frame("rst4", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, 4, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
